// File: rtl/tawas_regfile.sv
// ----------------------------------------------------------------------------
// tawas_regfile
//
// Register file for a 4-way barrel-threaded core: 4 thread banks x 8 registers
// x 32 bits. Two combinational read ports serve the arithmetic unit (AU) from
// the bank of the current thread slice. AU results are written back two slices
// later, to bank (slice + 2) mod 4. Load/store results arrive asynchronously
// to the thread schedule and share the single write port, so a small FIFO
// holds them while the AU owns the port.
//
// Write port arbitration, one commit per cycle:
//   1. AU writeback
//   2. load/store queue head (popped whenever the AU is idle)
//   3. load/store entry written straight through (AU idle, queue empty)
// An AU write invalidates queued load/store entries aimed at the same
// {thread, register}; the AU value is younger and must not be overwritten.
//
// Parameters:
//   NUM_LS_Q      load/store writeback queue depth, 1..4
//
// Compile-time option:
//   TAWAS_REGFILE_BYPASS_EN  when defined, a write committing this cycle to
//                            the bank being read is forwarded to au_ra/au_rb.
//                            When undefined, reads return array contents and a
//                            write becomes visible the cycle after commit.
//
// Ports:
//   clk           in   1   clock, rising edge
//   rst           in   1   asynchronous active-high reset
//   slice         in   2   current thread slice (read bank)
//   au_ra_sel     in   3   AU operand A register select
//   au_ra         out  32  AU operand A data (0-cycle read)
//   au_rb_sel     in   3   AU operand B register select
//   au_rb         out  32  AU operand B data (0-cycle read)
//   au_rc_vld     in   1   AU writeback valid
//   au_rc_sel     in   3   AU writeback register
//   au_rc         in   32  AU writeback data
//   ls_rc_vld     in   1   load/store writeback valid
//   ls_rc_thread  in   2   load/store writeback thread (bank)
//   ls_rc_sel     in   3   load/store writeback register
//   ls_rc         in   32  load/store writeback data
//   ls_rc_rdy     out  1   load/store writeback can be accepted this cycle
// ----------------------------------------------------------------------------
module tawas_regfile #(
  parameter int NUM_LS_Q = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  slice,
  input  logic [2:0]  au_ra_sel,
  output logic [31:0] au_ra,
  input  logic [2:0]  au_rb_sel,
  output logic [31:0] au_rb,
  input  logic        au_rc_vld,
  input  logic [2:0]  au_rc_sel,
  input  logic [31:0] au_rc,
  input  logic        ls_rc_vld,
  input  logic [1:0]  ls_rc_thread,
  input  logic [2:0]  ls_rc_sel,
  input  logic [31:0] ls_rc,
  output logic        ls_rc_rdy
);

  localparam int              CW    = $clog2(NUM_LS_Q + 1);
  localparam logic [CW-1:0]   DEPTH = CW'(NUM_LS_Q);

  // vld=0 marks an entry killed by a younger AU write; it is still popped in
  // order but performs no register write.
  typedef struct packed {
    logic        vld;
    logic [1:0]  thread;
    logic [2:0]  sel;
    logic [31:0] data;
  } ls_ent_t;

  logic [31:0]   r_regs [4][8];
  ls_ent_t       r_q [NUM_LS_Q];
  ls_ent_t       w_q_next [NUM_LS_Q];
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic [CW-1:0] w_tail;
  logic          r_ls_rc_rdy;

  logic [1:0]    w_au_bank;
  logic          w_q_empty;
  logic          w_ls_acc;
  logic          w_ls_direct;
  logic          w_pop;
  logic          w_push;

  logic          w_wr_en;
  logic [1:0]    w_wr_bank;
  logic [2:0]    w_wr_sel;
  logic [31:0]   w_wr_data;

  // 2-bit addition wraps, giving (slice + 2) mod 4.
  assign w_au_bank   = slice + 2'd2;
  assign w_q_empty   = (r_count == '0);
  assign w_ls_acc    = ls_rc_vld & r_ls_rc_rdy;
  assign w_ls_direct = w_ls_acc & ~au_rc_vld & w_q_empty;
  assign w_pop       = ~au_rc_vld & ~w_q_empty;
  assign w_push      = w_ls_acc & ~w_ls_direct;
  assign ls_rc_rdy   = r_ls_rc_rdy;

  // Write port arbitration.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path through
    // this block leaves a value unassigned and no latch is inferred.
    w_wr_en   = 1'b0;
    w_wr_bank = '0;
    w_wr_sel  = '0;
    w_wr_data = '0;
    if (au_rc_vld) begin
      w_wr_en   = 1'b1;
      w_wr_bank = w_au_bank;
      w_wr_sel  = au_rc_sel;
      w_wr_data = au_rc;
    end else if (w_pop) begin
      w_wr_en   = r_q[0].vld;
      w_wr_bank = r_q[0].thread;
      w_wr_sel  = r_q[0].sel;
      w_wr_data = r_q[0].data;
    end else if (w_ls_direct) begin
      w_wr_en   = 1'b1;
      w_wr_bank = ls_rc_thread;
      w_wr_sel  = ls_rc_sel;
      w_wr_data = ls_rc;
    end
  end

  // Queue next state: a shift FIFO with the head always at index 0.
  // Pops only happen with the AU idle and kills only with the AU active, so
  // the two never interact within one cycle.
  always_comb begin
    w_q_next     = r_q;
    w_count_next = r_count;
    w_tail       = r_count;

    if (au_rc_vld) begin
      for (int i = 0; i < NUM_LS_Q; i++) begin
        if (r_q[i].thread == w_au_bank && r_q[i].sel == au_rc_sel)
          w_q_next[i].vld = 1'b0;
      end
    end

    if (w_pop) begin
      for (int i = 0; i < NUM_LS_Q - 1; i++)
        w_q_next[i] = r_q[i + 1];
      w_q_next[NUM_LS_Q - 1] = '0;
      w_tail = r_count - CW'(1);
    end

    // A push is only possible while r_count < DEPTH, so w_tail is in range.
    if (w_push) begin
      for (int i = 0; i < NUM_LS_Q; i++) begin
        if (CW'(i) == w_tail)
          w_q_next[i] = '{vld: 1'b1, thread: ls_rc_thread, sel: ls_rc_sel, data: ls_rc};
      end
    end

    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Register array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this array is reset explicitly because software relies on every
      // register reading 0 after reset; that costs a reset on each flop.
      for (int b = 0; b < 4; b++)
        for (int r = 0; r < 8; r++)
          r_regs[b][r] <= '0;
    end else if (w_wr_en) begin
      // NOTE: non-blocking assignments for all clocked state, so every
      // always_ff samples pre-edge values regardless of evaluation order.
      r_regs[w_wr_bank][w_wr_sel] <= w_wr_data;
    end
  end

  // Queue state. Reset discards queued entries so nothing is written after
  // reset rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LS_Q; i++)
        r_q[i] <= '0;
      r_count     <= '0;
      r_ls_rc_rdy <= 1'b1;
    end else begin
      r_q         <= w_q_next;
      r_count     <= w_count_next;
      r_ls_rc_rdy <= (w_count_next < DEPTH);
    end
  end

  // Read ports.
  always_comb begin
`ifdef TAWAS_REGFILE_BYPASS_EN
    au_ra = (w_wr_en && w_wr_bank == slice && w_wr_sel == au_ra_sel) ?
            w_wr_data : r_regs[slice][au_ra_sel];
    au_rb = (w_wr_en && w_wr_bank == slice && w_wr_sel == au_rb_sel) ?
            w_wr_data : r_regs[slice][au_rb_sel];
`else
    au_ra = r_regs[slice][au_ra_sel];
    au_rb = r_regs[slice][au_rb_sel];
`endif
  end

endmodule

// File: tb/tb_tawas_regfile.sv
// ----------------------------------------------------------------------------
// tb_tawas_regfile
//
// Self-checking bench for tawas_regfile (NUM_LS_Q = 2). A behavioural model
// (register array plus a SystemVerilog queue of pending load/store writes) is
// stepped on each rising edge; a compare process checks au_ra, au_rb and
// ls_rc_rdy against it on every falling edge. Directed sequences with literal
// expectations come first, followed by randomized traffic with one reset
// asserted mid-stream.
// ----------------------------------------------------------------------------
module tb_tawas_regfile;

  localparam int N = 2;

  typedef struct packed {
    logic        vld;
    logic [1:0]  t;
    logic [2:0]  s;
    logic [31:0] d;
  } ent_t;

  logic        clk;
  logic        rst;
  logic [1:0]  slice;
  logic [2:0]  au_ra_sel;
  logic [31:0] au_ra;
  logic [2:0]  au_rb_sel;
  logic [31:0] au_rb;
  logic        au_rc_vld;
  logic [2:0]  au_rc_sel;
  logic [31:0] au_rc;
  logic        ls_rc_vld;
  logic [1:0]  ls_rc_thread;
  logic [2:0]  ls_rc_sel;
  logic [31:0] ls_rc;
  logic        ls_rc_rdy;

  tawas_regfile #(.NUM_LS_Q(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .slice        (slice),
    .au_ra_sel    (au_ra_sel),
    .au_ra        (au_ra),
    .au_rb_sel    (au_rb_sel),
    .au_rb        (au_rb),
    .au_rc_vld    (au_rc_vld),
    .au_rc_sel    (au_rc_sel),
    .au_rc        (au_rc),
    .ls_rc_vld    (ls_rc_vld),
    .ls_rc_thread (ls_rc_thread),
    .ls_rc_sel    (ls_rc_sel),
    .ls_rc        (ls_rc),
    .ls_rc_rdy    (ls_rc_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Behavioural model state.
  logic [31:0] m_regs [4][8];
  ent_t        m_q [$];
  bit          m_rdy;
  bit          m_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected value of a same-cycle read of a register being written.
  function automatic logic [31:0] byp(input logic [31:0] old_v, input logic [31:0] new_v);
`ifdef TAWAS_REGFILE_BYPASS_EN
    return new_v;
`else
    return old_v;
`endif
  endfunction

  task automatic model_reset();
    foreach (m_regs[b, r]) m_regs[b][r] = '0;
    m_q.delete();
    m_rdy = 1'b1;
    m_acc = 1'b0;
  endtask

  // The write that commits at the coming edge, from the current inputs.
  task automatic model_commit(output bit en, output logic [1:0] b,
                              output logic [2:0] s, output logic [31:0] d);
    en = 1'b0; b = '0; s = '0; d = '0;
    if (au_rc_vld) begin
      en = 1'b1; b = slice + 2'd2; s = au_rc_sel; d = au_rc;
    end else if (m_q.size() > 0) begin
      en = m_q[0].vld; b = m_q[0].t; s = m_q[0].s; d = m_q[0].d;
    end else if (ls_rc_vld && m_rdy) begin
      en = 1'b1; b = ls_rc_thread; s = ls_rc_sel; d = ls_rc;
    end
  endtask

  task automatic model_step();
    bit          en;
    logic [1:0]  b;
    logic [2:0]  s;
    logic [31:0] d;
    bit          acc;
    bit          direct;
    ent_t        h;
    acc    = ls_rc_vld && m_rdy;
    direct = acc && !au_rc_vld && (m_q.size() == 0);
    model_commit(en, b, s, d);
    if (au_rc_vld) begin
      foreach (m_q[i])
        if (m_q[i].t == b && m_q[i].s == s) m_q[i].vld = 1'b0;
    end else if (m_q.size() > 0) begin
      h = m_q.pop_front();
    end
    if (en) m_regs[b][s] = d;
    if (acc && !direct) m_q.push_back('{1'b1, ls_rc_thread, ls_rc_sel, ls_rc});
    m_rdy = (m_q.size() < N);
    m_acc = acc;
  endtask

  // Advance one clock: model follows the edge, inputs may change 1ns later.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic idle();
    au_rc_vld = 1'b0;
    ls_rc_vld = 1'b0;
  endtask

  // Compare process: DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      bit          en;
      logic [1:0]  b;
      logic [2:0]  s;
      logic [31:0] d;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      model_commit(en, b, s, d);
      exp_a = m_regs[slice][au_ra_sel];
      exp_b = m_regs[slice][au_rb_sel];
`ifdef TAWAS_REGFILE_BYPASS_EN
      if (en && b == slice && s == au_ra_sel) exp_a = d;
      if (en && b == slice && s == au_rb_sel) exp_b = d;
`endif
      check("cmp_au_ra", au_ra, exp_a);
      check("cmp_au_rb", au_rb, exp_b);
      check("cmp_ls_rc_rdy", {31'd0, ls_rc_rdy}, {31'd0, m_rdy});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    slice = '0; au_ra_sel = '0; au_rb_sel = '0;
    au_rc_sel = '0; au_rc = '0;
    ls_rc_thread = '0; ls_rc_sel = '0; ls_rc = '0;
    idle();
    model_reset();
    #12;
    check("reset_au_ra", au_ra, 32'h0);
    check("reset_au_rb", au_rb, 32'h0);
    check("reset_rdy", {31'd0, ls_rc_rdy}, 32'd1);
    #1 rst = 1'b0;
    tick();
    cmp_en = 1'b1;

    // AU writeback lands two slices ahead.
    slice = 2'd1; au_rc_vld = 1'b1; au_rc_sel = 3'd4; au_rc = 32'h1234_5678;
    tick();
    idle();
    slice = 2'd3; au_ra_sel = 3'd4; au_rb_sel = 3'd4;
    #1 check("au_wb_bank3", au_ra, 32'h1234_5678);
    slice = 2'd0;
    #1 check("au_wb_bank0_clean", au_rb, 32'h0);
    slice = 2'd1;
    #1 check("au_wb_bank1_clean", au_rb, 32'h0);
    tick();
    slice = 2'd2;
    #1 check("au_wb_bank2_clean", au_rb, 32'h0);
    tick();

    // Direct load/store write with the AU idle and queue empty.
    ls_rc_vld = 1'b1; ls_rc_thread = 2'd2; ls_rc_sel = 3'd1; ls_rc = 32'hDEAD_BEEF;
    #1 check("ls_direct_rdy_before", {31'd0, ls_rc_rdy}, 32'd1);
    tick();
    idle();
    slice = 2'd2; au_ra_sel = 3'd1;
    #1 check("ls_direct_data", au_ra, 32'hDEAD_BEEF);
    check("ls_direct_rdy_after", {31'd0, ls_rc_rdy}, 32'd1);
    check("ls_direct_model_q", 32'(m_q.size()), 32'd0);
    tick();

    // Collision: AU wins, load/store entry queued then drained.
    slice = 2'd0; au_rc_vld = 1'b1; au_rc_sel = 3'd2; au_rc = 32'hAAAA_0001;
    ls_rc_vld = 1'b1; ls_rc_thread = 2'd1; ls_rc_sel = 3'd3; ls_rc = 32'hBBBB_0002;
    tick();
    idle();
    check("collision_model_count", 32'(m_q.size()), 32'd1);
    slice = 2'd2; au_ra_sel = 3'd2;
    #1 check("collision_au_data", au_ra, 32'hAAAA_0001);
    check("collision_rdy", {31'd0, ls_rc_rdy}, 32'd1);
    slice = 2'd1; au_rb_sel = 3'd3;
    #1 check("collision_ls_pending", au_rb, byp(32'h0, 32'hBBBB_0002));
    tick();
    #1 check("collision_ls_drained", au_rb, 32'hBBBB_0002);
    check("collision_model_empty", 32'(m_q.size()), 32'd0);
    tick();

    // Queue full: three AU+ls cycles, the third ls entry is held.
    slice = 2'd0; au_ra_sel = 3'd6;
    for (int k = 1; k <= 3; k++) begin
      au_rc_vld = 1'b1; au_rc_sel = 3'd0; au_rc = 32'h100 + k;
      ls_rc_vld = 1'b1; ls_rc_thread = 2'd0; ls_rc_sel = 3'd6; ls_rc = 32'(k);
      #1 check($sformatf("qfull_rdy_%0d", k), {31'd0, ls_rc_rdy}, (k < 3) ? 32'd1 : 32'd0);
      tick();
    end
    au_rc_vld = 1'b0;
    #1 check("qfull_hold_rdy", {31'd0, ls_rc_rdy}, 32'd0);
    check("qfull_model_count", 32'(m_q.size()), 32'd2);
    tick();
    #1 check("qfull_rdy_reopen", {31'd0, ls_rc_rdy}, 32'd1);
    check("qfull_order_1", au_ra, byp(32'd1, 32'd2));
    tick();
    ls_rc_vld = 1'b0;
    #1 check("qfull_order_2", au_ra, byp(32'd2, 32'd3));
    tick();
    #1 check("qfull_order_3", au_ra, 32'd3);
    check("qfull_model_empty", 32'(m_q.size()), 32'd0);
    tick();

    // Stale queued entry killed by a younger AU write to the same register.
    slice = 2'd0; au_rc_vld = 1'b1; au_rc_sel = 3'd7; au_rc = 32'h77;
    ls_rc_vld = 1'b1; ls_rc_thread = 2'd0; ls_rc_sel = 3'd5; ls_rc = 32'h1;
    tick();
    ls_rc_vld = 1'b0;
    slice = 2'd2; au_rc_vld = 1'b1; au_rc_sel = 3'd5; au_rc = 32'h2;
    tick();
    idle();
    slice = 2'd0; au_ra_sel = 3'd5;
    #1 check("stale_after_au", au_ra, 32'h2);
    check("stale_model_killed", {31'd0, m_q[0].vld}, 32'd0);
    tick();
    #1 check("stale_final", au_ra, 32'h2);
    check("stale_model_empty", 32'(m_q.size()), 32'd0);
    tick();

    // Same-cycle read of a register being written.
    slice = 2'd1; au_ra_sel = 3'd0;
    ls_rc_vld = 1'b1; ls_rc_thread = 2'd1; ls_rc_sel = 3'd0; ls_rc = 32'hCAFE_F00D;
    #1 check("bypass_same_cycle", au_ra, byp(32'h0, 32'hCAFE_F00D));
    tick();
    idle();
    #1 check("bypass_next_cycle", au_ra, 32'hCAFE_F00D);
    tick();

    // Randomized traffic, producer holds a refused load/store entry.
    for (int c = 0; c < 2000; c++) begin
      if (c == 1000) begin
        idle();
        #2 rst = 1'b1;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        #1 check("midrst_rdy", {31'd0, ls_rc_rdy}, 32'd1);
        check("midrst_model_empty", 32'(m_q.size()), 32'd0);
      end
      slice     = 2'($urandom);
      au_ra_sel = 3'($urandom);
      au_rb_sel = 3'($urandom);
      au_rc_vld = ($urandom_range(0, 9) < 6);
      au_rc_sel = 3'($urandom);
      au_rc     = $urandom;
      if (!(ls_rc_vld && !m_acc)) begin
        ls_rc_vld    = ($urandom_range(0, 2) != 0);
        ls_rc_thread = 2'($urandom);
        ls_rc_sel    = 3'($urandom);
        ls_rc        = $urandom;
      end
      // Keep a same-cycle AU write and load/store entry off the same register.
      if (au_rc_vld && ls_rc_vld && ls_rc_thread == 2'(slice + 2'd2) && ls_rc_sel == au_rc_sel)
        au_rc_sel = au_rc_sel ^ 3'd1;
      tick();
    end

    idle();
    tick();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
